// File: rtl/time_of_day_counter.sv
// Hours/minutes/seconds time-of-day counter with a prescaler, validated load and optional alarm.
// Define TOD_ALARM_EN to build the sticky alarm; otherwise alarm is tied low.
module time_of_day_counter #(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned HOURS   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [4:0] load_hr,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  output logic       load_err,
  output logic [4:0] hr,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       sec_tick,
  output logic       day_wrap,
  input  logic       alarm_set,
  input  logic [4:0] alarm_hr,
  input  logic [5:0] alarm_min,
  input  logic       alarm_ack,
  output logic       alarm
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PreMax = PW'(CLK_DIV - 1);
  localparam logic [4:0] HrMax = 5'(HOURS - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [4:0]    hr_q, hr_d;
  logic [5:0]    min_q, min_d, sec_q, sec_d;
  logic          tick_q, tick_d, wrap_q, wrap_d, err_q, err_d;

  logic       adv, adv_taken, load_ok, wrap;
  logic [4:0] nhr;
  logic [5:0] nmin, nsec;

  // Time after one advance, with all carries resolved in the same cycle.
  always_comb begin
    nsec = sec_q + 6'd1;
    nmin = min_q;
    nhr  = hr_q;
    wrap = 1'b0;
    if (sec_q == 6'd59) begin
      nsec = 6'd0;
      if (min_q == 6'd59) begin
        nmin = 6'd0;
        if (hr_q == HrMax) begin
          nhr  = 5'd0;
          wrap = 1'b1;
        end else begin
          nhr = hr_q + 5'd1;
        end
      end else begin
        nmin = min_q + 6'd1;
      end
    end
  end

  always_comb begin
    adv       = en && (pre_q == PreMax);
    adv_taken = adv && !load;
    load_ok   = (load_sec < 6'd60) && (load_min < 6'd60) && ({1'b0, load_hr} < 6'(HOURS));
    pre_d     = pre_q;
    hr_d      = hr_q;
    min_d     = min_q;
    sec_d     = sec_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    // Any load, accepted or not, suppresses the advance for this cycle.
    if (load) begin
      if (load_ok) begin
        hr_d  = load_hr;
        min_d = load_min;
        sec_d = load_sec;
        pre_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
      if (adv) begin
        pre_d  = '0;
        hr_d   = nhr;
        min_d  = nmin;
        sec_d  = nsec;
        tick_d = 1'b1;
        wrap_d = wrap;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q  <= '0;
      hr_q   <= '0;
      min_q  <= '0;
      sec_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      hr_q   <= hr_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign hr       = hr_q;
  assign min      = min_q;
  assign sec      = sec_q;
  assign sec_tick = tick_q;
  assign day_wrap = wrap_q;
  assign load_err = err_q;

`ifdef TOD_ALARM_EN
  logic [4:0] al_hr_q, al_hr_d;
  logic [5:0] al_min_q, al_min_d;
  logic       alarm_q, alarm_d;

  // Out-of-range alarm times are stored but can never equal a reachable time.
  always_comb begin
    al_hr_d  = alarm_set ? alarm_hr : al_hr_q;
    al_min_d = alarm_set ? alarm_min : al_min_q;
    alarm_d  = alarm_q && !alarm_ack;
    if (adv_taken && (nhr == al_hr_q) && (nmin == al_min_q) && (nsec == 6'd0)) begin
      alarm_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      al_hr_q  <= '0;
      al_min_q <= '0;
      alarm_q  <= 1'b0;
    end else begin
      al_hr_q  <= al_hr_d;
      al_min_q <= al_min_d;
      alarm_q  <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_set, alarm_hr, alarm_min, alarm_ack, adv_taken};
  assign alarm        = 1'b0;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Randomized bench for time_of_day_counter: a seconds-of-day model checked every cycle,
// plus directed literal checks. Alarm expectations follow TOD_ALARM_EN.
module tb_time_of_day_counter;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned HOURS   = 24;
  localparam int DAY = HOURS * 3600;

  logic       clk = 1'b0;
  logic       rst, en, load, alarm_set, alarm_ack;
  logic [4:0] load_hr, alarm_hr;
  logic [5:0] load_min, load_sec, alarm_min;
  logic       d_err, d_tick, d_wrap, d_alarm;
  logic [4:0] d_hr;
  logic [5:0] d_min, d_sec;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  time_of_day_counter #(.CLK_DIV(CLK_DIV), .HOURS(HOURS)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_hr  (load_hr),
    .load_min (load_min),
    .load_sec (load_sec),
    .load_err (d_err),
    .hr       (d_hr),
    .min      (d_min),
    .sec      (d_sec),
    .sec_tick (d_tick),
    .day_wrap (d_wrap),
    .alarm_set(alarm_set),
    .alarm_hr (alarm_hr),
    .alarm_min(alarm_min),
    .alarm_ack(alarm_ack),
    .alarm    (d_alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time as seconds since midnight, prescaler as a plain count.
  int t = 0, p = 0, ah = 0, am = 0;
  bit m_tick = 0, m_wrap = 0, m_err = 0, m_alarm = 0, m_adv = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t = 0; p = 0; ah = 0; am = 0;
      m_tick = 0; m_wrap = 0; m_err = 0; m_alarm = 0;
    end else begin
      m_adv = 0; m_tick = 0; m_wrap = 0; m_err = 0;
      if (load) begin
        if (load_sec < 60 && load_min < 60 && load_hr < HOURS) begin
          t = load_hr * 3600 + load_min * 60 + load_sec;
          p = 0;
        end else begin
          m_err = 1;
        end
      end else if (en) begin
        if (p == CLK_DIV - 1) begin
          p = 0;
          t = t + 1;
          m_adv = 1;
          m_tick = 1;
          if (t == DAY) begin
            t = 0;
            m_wrap = 1;
          end
        end else begin
          p = p + 1;
        end
      end
`ifdef TOD_ALARM_EN
      if (alarm_ack) m_alarm = 0;
      if (m_adv && ah < HOURS && am < 60 && t == ah * 3600 + am * 60) m_alarm = 1;
      if (alarm_set) begin
        ah = alarm_hr;
        am = alarm_min;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_hr", d_hr, t / 3600);
      chk("cmp_min", d_min, (t / 60) % 60);
      chk("cmp_sec", d_sec, t % 60);
      chk("cmp_tick", d_tick, m_tick);
      chk("cmp_wrap", d_wrap, m_wrap);
      chk("cmp_err", d_err, m_err);
      chk("cmp_alarm", d_alarm, m_alarm);
    end
  end

  task automatic do_load(input int h, input int m, input int s);
    load = 1'b1;
    load_hr = 5'(h);
    load_min = 6'(m);
    load_sec = 6'(s);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic set_alarm(input int h, input int m);
    alarm_set = 1'b1;
    alarm_hr = 5'(h);
    alarm_min = 6'(m);
    @(negedge clk);
    alarm_set = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; alarm_set = 1'b0; alarm_ack = 1'b0;
    load_hr = '0; load_min = '0; load_sec = '0; alarm_hr = '0; alarm_min = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    rst = 1'b1;
    en = 1'b1;
    chk("rst_hr", d_hr, 0);
    chk("rst_sec", d_sec, 0);
    chk("rst_alarm", d_alarm, 0);

    // First advance CLK_DIV enabled cycles after release.
    repeat (3) @(negedge clk);
    chk("div_sec3", d_sec, 0);
    @(negedge clk);
    chk("div_sec4", d_sec, 1);
    chk("div_tick4", d_tick, 1);
    repeat (4) @(negedge clk);
    chk("div_sec8", d_sec, 2);

    // Day wrap.
    do_load(23, 59, 59);
    chk("wrap_pre_hr", d_hr, 23);
    repeat (3) @(negedge clk);
    chk("wrap_pre_sec", d_sec, 59);
    @(negedge clk);
    chk("wrap_hr", d_hr, 0);
    chk("wrap_min", d_min, 0);
    chk("wrap_sec", d_sec, 0);
    chk("wrap_pulse", d_wrap, 1);
    chk("wrap_tick", d_tick, 1);
    @(negedge clk);
    chk("wrap_pulse_end", d_wrap, 0);

    // Rejected load.
    do_load(12, 60, 0);
    chk("bad_err", d_err, 1);
    chk("bad_hr", d_hr, 0);
    @(negedge clk);
    chk("bad_err_end", d_err, 0);

    // Load landing on an advance cycle wins and restarts the prescaler.
    do_load(1, 2, 3);
    repeat (3) @(negedge clk);
    do_load(12, 30, 0);
    chk("ldadv_hr", d_hr, 12);
    chk("ldadv_min", d_min, 30);
    chk("ldadv_sec", d_sec, 0);
    chk("ldadv_tick", d_tick, 0);
    repeat (3) @(negedge clk);
    chk("ldadv_sec3", d_sec, 0);
    @(negedge clk);
    chk("ldadv_sec4", d_sec, 1);

    // Freeze with en low mid-count.
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    chk("frz_sec", d_sec, 1);
    en = 1'b1;
    @(negedge clk);
    chk("frz_resume1", d_sec, 1);
    @(negedge clk);
    chk("frz_resume2", d_sec, 2);

    // Load while disabled.
    en = 1'b0;
    do_load(5, 6, 7);
    chk("ld_dis_hr", d_hr, 5);
    chk("ld_dis_sec", d_sec, 7);
    en = 1'b1;

`ifdef TOD_ALARM_EN
    set_alarm(7, 15);
    do_load(7, 14, 59);
    repeat (4) @(negedge clk);
    chk("al_min", d_min, 15);
    chk("al_set", d_alarm, 1);
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    chk("al_ack", d_alarm, 0);
    do_load(7, 15, 0);
    repeat (5) @(negedge clk);
    chk("al_load_nomatch", d_alarm, 0);
    set_alarm(7, 60);
    do_load(7, 59, 59);
    repeat (4) @(negedge clk);
    chk("al_oor_hr", d_hr, 8);
    chk("al_oor", d_alarm, 0);
    set_alarm(9, 0);
    do_load(8, 59, 59);
    repeat (3) @(negedge clk);
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    chk("al_ack_vs_match", d_alarm, 1);
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
`else
    set_alarm(7, 15);
    do_load(7, 14, 59);
    repeat (4) @(negedge clk);
    chk("al_off_min", d_min, 15);
    chk("al_off", d_alarm, 0);
`endif

    // Asynchronous reset just before a day wrap.
    do_load(23, 59, 59);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_hr", d_hr, 0);
    chk("arst_min", d_min, 0);
    chk("arst_sec", d_sec, 0);
    chk("arst_wrap", d_wrap, 0);
    chk("arst_tick", d_tick, 0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      en = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 39) == 0);
      load_hr = ($urandom_range(0, 3) == 0) ? 5'(HOURS - 1) : 5'($urandom_range(0, HOURS));
      load_min = ($urandom_range(0, 3) == 0) ? 6'd59 : 6'($urandom_range(0, 60));
      load_sec = 6'($urandom_range(54, 60));
      alarm_set = ($urandom_range(0, 49) == 0);
      alarm_hr = 5'($urandom_range(0, HOURS));
      alarm_min = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 60));
      alarm_ack = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    load = 1'b0; alarm_set = 1'b0; alarm_ack = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
